// File: rtl/rob_pkg.sv
// Shared sizing constants and the entry layout for the reorder buffer.
package rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_IX_W   = 3;
  localparam int REG_ADDR_W = 5;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_CNT_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mispredict;
    logic [REG_ADDR_W-1:0] dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, in-order
// retire, with a full flush when a mispredicted branch reaches the head.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  alloc_valid_in,
  input  logic [REG_ADDR_W-1:0]                 alloc_dest_in,
  output logic                                  alloc_ready_out,
  output logic [ROB_IX_W-1:0]                   alloc_ix_out,
  input  logic                                  wb_valid_in,
  input  logic [ROB_IX_W-1:0]                   wb_ix_in,
  input  logic [DATA_WIDTH-1:0]                 wb_data_in,
  input  logic                                  wb_mispredict_in,
  output logic                                  commit_we_out,
  output logic [REG_ADDR_W-1:0]                 commit_addr_out,
  output logic [DATA_WIDTH-1:0]                 commit_data_out,
  output logic [ROB_IX_W-1:0]                   commit_ix_out,
  output logic                                  flush_out,
  output logic [ROB_DEPTH-1:0][REG_ADDR_W-1:0]  flush_addrs_out,
  input  logic [ROB_IX_W-1:0]                   rd_ix1_in,
  input  logic [ROB_IX_W-1:0]                   rd_ix2_in,
  output logic [DATA_WIDTH-1:0]                 rd_data1_out,
  output logic [DATA_WIDTH-1:0]                 rd_data2_out,
  output logic                                  rd_ready1_out,
  output logic                                  rd_ready2_out,
  output logic [ROB_CNT_W-1:0]                  count_out
);

  rob_entry_t           entries_q [ROB_DEPTH];
  rob_entry_t           entries_d [ROB_DEPTH];
  logic [ROB_IX_W-1:0]  head_q, head_d;
  logic [ROB_IX_W-1:0]  tail_q, tail_d;
  logic [ROB_CNT_W-1:0] count_q, count_d;

  logic commitValid;
  logic allocFire;

  // Retirement is purely combinational off the head; a full ROB stays full this cycle.
  assign commitValid     = entries_q[head_q].valid && entries_q[head_q].done;
  assign flush_out       = commitValid && entries_q[head_q].mispredict;
  assign alloc_ready_out = (count_q < ROB_CNT_W'(ROB_DEPTH)) && !flush_out;
  assign allocFire       = alloc_valid_in && alloc_ready_out;
  assign alloc_ix_out    = alloc_ready_out ? tail_q : '0;
  assign count_out       = count_q;

  always_comb begin
    commit_we_out   = 1'b0;
    commit_addr_out = '0;
    commit_data_out = '0;
    commit_ix_out   = '0;
    if (commitValid) begin
      commit_we_out   = (entries_q[head_q].dest != '0);
      commit_addr_out = entries_q[head_q].dest;
      commit_data_out = entries_q[head_q].data;
      commit_ix_out   = head_q;
    end
  end

  // Every valid entry other than the head is younger, since valid entries are contiguous.
  always_comb begin
    flush_addrs_out = '0;
    if (flush_out) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (entries_q[i].valid && (head_q != ROB_IX_W'(i))) begin
          flush_addrs_out[i] = entries_q[i].dest;
        end
      end
    end
  end

  always_comb begin
    rd_ready1_out = entries_q[rd_ix1_in].valid && entries_q[rd_ix1_in].done;
    rd_data1_out  = entries_q[rd_ix1_in].data;
    rd_ready2_out = entries_q[rd_ix2_in].valid && entries_q[rd_ix2_in].done;
    rd_data2_out  = entries_q[rd_ix2_in].data;
    if (wb_valid_in && (wb_ix_in == rd_ix1_in)) begin
      rd_ready1_out = 1'b1;
      rd_data1_out  = wb_data_in;
    end
    if (wb_valid_in && (wb_ix_in == rd_ix2_in)) begin
      rd_ready2_out = 1'b1;
      rd_data2_out  = wb_data_in;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush_out) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid      = 1'b0;
        entries_d[i].done       = 1'b0;
        entries_d[i].mispredict = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_valid_in && entries_q[wb_ix_in].valid) begin
        entries_d[wb_ix_in].done       = 1'b1;
        entries_d[wb_ix_in].data       = wb_data_in;
        entries_d[wb_ix_in].mispredict = wb_mispredict_in;
      end
      if (commitValid) begin
        entries_d[head_q].valid = 1'b0;
        entries_d[head_q].done  = 1'b0;
        head_d                  = head_q + 1'b1;
      end
      if (allocFire) begin
        entries_d[tail_q].valid      = 1'b1;
        entries_d[tail_q].done       = 1'b0;
        entries_d[tail_q].mispredict = 1'b0;
        entries_d[tail_q].dest       = alloc_dest_in;
        tail_d                       = tail_q + 1'b1;
      end
      count_d = count_q + ROB_CNT_W'(allocFire) - ROB_CNT_W'(commitValid);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer: stimulus pushes expected
// commits/flushes, a negedge monitor pops and compares them.
module tb_reorder_buffer;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            alloc_valid_in;
  logic [4:0]      alloc_dest_in;
  logic            alloc_ready_out;
  logic [2:0]      alloc_ix_out;
  logic            wb_valid_in;
  logic [2:0]      wb_ix_in;
  logic [31:0]     wb_data_in;
  logic            wb_mispredict_in;
  logic            commit_we_out;
  logic [4:0]      commit_addr_out;
  logic [31:0]     commit_data_out;
  logic [2:0]      commit_ix_out;
  logic            flush_out;
  logic [7:0][4:0] flush_addrs_out;
  logic [2:0]      rd_ix1_in;
  logic [2:0]      rd_ix2_in;
  logic [31:0]     rd_data1_out;
  logic [31:0]     rd_data2_out;
  logic            rd_ready1_out;
  logic            rd_ready2_out;
  logic [3:0]      count_out;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [39:0] expCommitQ[$];
  logic [39:0] expFlushQ[$];

  reorder_buffer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .alloc_valid_in  (alloc_valid_in),
    .alloc_dest_in   (alloc_dest_in),
    .alloc_ready_out (alloc_ready_out),
    .alloc_ix_out    (alloc_ix_out),
    .wb_valid_in     (wb_valid_in),
    .wb_ix_in        (wb_ix_in),
    .wb_data_in      (wb_data_in),
    .wb_mispredict_in(wb_mispredict_in),
    .commit_we_out   (commit_we_out),
    .commit_addr_out (commit_addr_out),
    .commit_data_out (commit_data_out),
    .commit_ix_out   (commit_ix_out),
    .flush_out       (flush_out),
    .flush_addrs_out (flush_addrs_out),
    .rd_ix1_in       (rd_ix1_in),
    .rd_ix2_in       (rd_ix2_in),
    .rd_data1_out    (rd_data1_out),
    .rd_data2_out    (rd_data2_out),
    .rd_ready1_out   (rd_ready1_out),
    .rd_ready2_out   (rd_ready2_out),
    .count_out       (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic allocValid, input logic [4:0] allocDest,
                               input logic wbValid, input logic [2:0] wbIx,
                               input logic [31:0] wbData, input logic wbMis);
    alloc_valid_in   = allocValid;
    alloc_dest_in    = allocDest;
    wb_valid_in      = wbValid;
    wb_ix_in         = wbIx;
    wb_data_in       = wbData;
    wb_mispredict_in = wbMis;
  endtask

  task automatic nextCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pushCommit(input logic [2:0] ix, input logic [4:0] addr,
                            input logic [31:0] data);
    expCommitQ.push_back({ix, addr, data});
  endtask

  task automatic doReset(input logic allocDuringReset);
    rst_in = 1'b1;
    applyStimulus(allocDuringReset, 5'd1, allocDuringReset, 3'd0, 32'hFF, allocDuringReset);
    nextCycle();
    nextCycle();
    rst_in = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  // Scoreboard monitor: pops one expected commit per write-enabled retirement and one per flush.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (commit_we_out) begin
        if (expCommitQ.size() == 0) begin
          checkOutput("unexpectedCommit", {commit_ix_out, commit_addr_out, commit_data_out}, 40'd0);
        end else begin
          checkOutput("commit{ix,addr,data}", {commit_ix_out, commit_addr_out, commit_data_out},
                      expCommitQ.pop_front());
        end
      end
      if (flush_out) begin
        if (expFlushQ.size() == 0) begin
          checkOutput("unexpectedFlush", 40'd1, 40'd0);
        end else begin
          checkOutput("flushAddrs", flush_addrs_out, expFlushQ.pop_front());
        end
      end else begin
        checkOutput("flushAddrsIdle", flush_addrs_out, 40'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0][4:0] flushExp;
    rd_ix1_in = 3'd0;
    rd_ix2_in = 3'd0;
    doReset(1'b0);

    @(negedge clk_in);
    checkOutput("resetReady",   alloc_ready_out, 1);
    checkOutput("resetCount",   count_out, 0);
    checkOutput("resetWe",      commit_we_out, 0);
    checkOutput("resetFlush",   flush_out, 0);
    checkOutput("resetAllocIx", alloc_ix_out, 0);
    nextCycle();

    // Fill the ROB with dests 1..8
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 5'(k + 1), 1'b0, 3'd0, 32'd0, 1'b0);
      @(negedge clk_in);
      checkOutput("fillAllocIx", alloc_ix_out, 40'(k));
      checkOutput("fillReady",   alloc_ready_out, 1);
      nextCycle();
    end
    applyStimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("fullReady", alloc_ready_out, 0);
    checkOutput("fullCount", count_out, 8);
    nextCycle();

    // Out-of-order writebacks 2,1,0 then in-order retirement
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd2, 32'hA, 1'b0);
    rd_ix1_in = 3'd3;
    @(negedge clk_in);
    checkOutput("lookupNotDone", rd_ready1_out, 0);
    nextCycle();

    applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'hB, 1'b0);
    rd_ix1_in = 3'd1;
    rd_ix2_in = 3'd2;
    @(negedge clk_in);
    checkOutput("bypassReady", rd_ready1_out, 1);
    checkOutput("bypassData",  rd_data1_out, 32'hB);
    checkOutput("lookupReady", rd_ready2_out, 1);
    checkOutput("lookupData",  rd_data2_out, 32'hA);
    nextCycle();

    pushCommit(3'd0, 5'd1, 32'hC);
    pushCommit(3'd1, 5'd2, 32'hB);
    pushCommit(3'd2, 5'd3, 32'hA);
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'hC, 1'b0);
    @(negedge clk_in);
    checkOutput("headWbNoCommit", commit_we_out, 0);
    nextCycle();

    // Full ROB with a commit and an alloc request: no allocation this cycle
    applyStimulus(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("fullCommitReady", alloc_ready_out, 0);
    checkOutput("fullCommitCount", count_out, 8);
    nextCycle();
    @(negedge clk_in);
    checkOutput("wrapReady",   alloc_ready_out, 1);
    checkOutput("wrapAllocIx", alloc_ix_out, 0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("allocCommitCount", count_out, 7);
    nextCycle();
    @(negedge clk_in);
    checkOutput("afterCommitsCount", count_out, 6);
    checkOutput("afterCommitsWe",    commit_we_out, 0);
    checkOutput("commitQueueDrained", 40'(expCommitQ.size()), 0);
    nextCycle();

    // x0 destination retires without a register write
    doReset(1'b1);
    @(negedge clk_in);
    checkOutput("resetOverrideCount", count_out, 0);
    checkOutput("resetOverrideReady", alloc_ready_out, 1);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd10, 1'b0, 3'd0, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'h55, 1'b0);
    nextCycle();
    pushCommit(3'd1, 5'd10, 32'h66);
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'h66, 1'b0);
    @(negedge clk_in);
    checkOutput("x0We",    commit_we_out, 0);
    checkOutput("x0Data",  commit_data_out, 32'h55);
    checkOutput("x0Count", count_out, 2);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("x0RetiredCount", count_out, 1);
    nextCycle();
    @(negedge clk_in);
    checkOutput("x0EmptyCount", count_out, 0);
    nextCycle();

    // Mispredicted branch at ix1 with younger entries 2..4
    doReset(1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 5'(k + 3), 1'b0, 3'd0, 32'd0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 32'h100, 1'b0);
    nextCycle();
    pushCommit(3'd0, 5'd3, 32'h100);
    pushCommit(3'd1, 5'd4, 32'h200);
    flushExp    = '0;
    flushExp[2] = 5'd5;
    flushExp[3] = 5'd6;
    flushExp[4] = 5'd7;
    expFlushQ.push_back(flushExp);
    applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 32'h200, 1'b1);
    @(negedge clk_in);
    checkOutput("preFlushCount", count_out, 5);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 1'b1, 3'd2, 32'h300, 1'b0);
    @(negedge clk_in);
    checkOutput("flushAsserted",   flush_out, 1);
    checkOutput("flushAllocReady", alloc_ready_out, 0);
    checkOutput("flushCount",      count_out, 4);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    rd_ix1_in = 3'd2;
    @(negedge clk_in);
    checkOutput("postFlushFlush",   flush_out, 0);
    checkOutput("postFlushCount",   count_out, 0);
    checkOutput("postFlushReady",   alloc_ready_out, 1);
    checkOutput("postFlushAllocIx", alloc_ix_out, 0);
    checkOutput("postFlushWbIgnored", rd_ready1_out, 0);
    nextCycle();
    applyStimulus(1'b1, 5'd11, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("postFlushAlloc", alloc_ix_out, 0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    @(negedge clk_in);
    checkOutput("postFlushAllocCount", count_out, 1);
    checkOutput("finalCommitQueue", 40'(expCommitQ.size()), 0);
    checkOutput("finalFlushQueue",  40'(expFlushQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The parameter ROB_DEPTH SHALL default to 8 and means entry count; the index is 3 bits.
REQ-002 The parameter DATA_WIDTH SHALL default to 32 and means the result width.
REQ-003 The ports SHALL be:
- clk_in  in  1  sole clock
- rst_in  in  1  synchronous active-high reset
- alloc_valid_in  in  1  dispatch requests an entry
- alloc_dest_in  in  5  architectural destination
- alloc_ready_out  out  1  entry available
- alloc_ix_out  out  3  index granted (tail)
- wb_valid_in  in  1  result broadcast
- wb_ix_in  in  3  entry being completed
- wb_data_in  in  32  result
- wb_mispredict_in  in  1  completing branch mispredicted
- commit_we_out  out  1  register-file write enable
- commit_addr_out  out  5  register-file write address
- commit_data_out  out  32  register-file write data
- commit_ix_out  out  3  index of retiring entry
- flush_out  out  1  speculative state discarded
- flush_addrs_out  out  8x5  destinations of all flushed entries
- rd_ix1_in, rd_ix2_in  in  3  operand lookup indices
- rd_data1_out, rd_data2_out  out  32  entry values
- rd_ready1_out, rd_ready2_out  out  1  entry value valid
- count_out  out  4  occupied entries

Function
REQ-004 Each entry SHALL hold valid, done, mispredict, dest[4:0] and data[31:0]; the head and tail pointers SHALL be 3 bits and wrap modulo 8.
REQ-005 alloc_ready_out SHALL be (count<8) && !flush_out, combinational; a full ROB SHALL NOT be relieved by a same-cycle commit.
REQ-006 An allocation SHALL occur on a clock edge where alloc_valid_in && alloc_ready_out; the entry at tail becomes valid with done=0, tail increments, and alloc_ix_out equals the pre-increment tail.
REQ-007 A writeback SHALL set done, data and mispredict of entry wb_ix_in at the edge; a writeback to an invalid entry SHALL be ignored.
REQ-008 A commit SHALL occur combinationally whenever the head entry is valid && done; commit_ix_out=head, commit_addr_out=dest and commit_data_out=data; at the edge the entry is invalidated and head increments.
REQ-009 commit_we_out SHALL be asserted on commit only when dest!=0; an x0 entry SHALL still retire.
REQ-010 A write-back to the head entry SHALL commit no earlier than the following cycle, because done is registered.
REQ-011 Simultaneous allocation and commit SHALL leave count unchanged; count_out SHALL equal valid entries (0..8).
REQ-012 When the committing head has mispredict=1, flush_out SHALL be asserted that same cycle and the branch itself SHALL commit normally.
REQ-013 During a flush, flush_addrs_out[i] SHALL be the dest of entry i if it is valid and younger than head, else 0.
REQ-014 At the flush edge, all entries SHALL be invalidated, head=tail=0, count=0, and concurrent alloc and writeback SHALL be ignored.
REQ-015 Lookup rd_readyN_out SHALL be valid && done for entry rd_ixN_in, with rd_dataN_out being the entry data.
REQ-016 Lookup SHALL bypass a same-cycle writeback with matching index (ready=1, data=wb_data_in).
REQ-017 Outputs other than lookups SHALL be 0 when not asserted.

Reset
REQ-018 On rst_in at a clock edge, all valid/done/mispredict bits, head, tail and count SHALL clear; data/dest need not clear.
REQ-019 After reset, alloc_ready_out=1, count_out=0, and commit_we_out=flush_out=0.
REQ-020 Reset SHALL override simultaneous alloc, writeback and flush.

Structure
REQ-021 The package rob_pkg SHALL hold ROB_DEPTH, ROB_IX_W=3, REG_ADDR_W=5 and the rob_entry_t struct.
REQ-022 The block SHALL be a single module with no sub-module.

Verification
REQ-023 Reset, then 8 allocs (dest 1..8) -> alloc_ix_out 0..7, count_out=8, alloc_ready_out=0 on the 9th cycle.
REQ-024 Writebacks to ix 2, 1, 0 (data 0xA,0xB,0xC) -> commits in order ix0,1,2 on consecutive cycles with data 0xC,0xB,0xA.
REQ-025 Dest=0 entry done -> retires, commit_we_out=0, head advances.
REQ-026 Mispredicted branch at ix1, entries 2..4 dest 5,6,7 -> one-cycle flush_out, flush_addrs_out[2..4]=5,6,7 and others 0, count_out=0, next alloc_ix_out=0.
REQ-027 Full ROB plus commit plus alloc_valid_in in the same cycle -> no allocation; alloc at tail 0 after wrap-around succeeds the next cycle.
